fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2, number of buffered fetch entries; legal values 2 and 4 only.
REQ-002 The module SHALL have port clock, input, 1, single rising-edge clock for all state.
REQ-003 The module SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clock.
REQ-004 The module SHALL have port in_valid, input, 1, fetch stage presents an entry this cycle.
REQ-005 The module SHALL have port in_pc_plus_1, input, 32, fetch-side incremented PC for the entry.
REQ-006 The module SHALL have port in_insn, input, 32, instruction word read from imem for the entry.
REQ-007 The module SHALL have port in_ready, output, 1, queue accepts an entry this cycle.
REQ-008 The module SHALL have port flush, input, 1, execute-stage taken-jump/branch indication; discards all buffered entries.
REQ-009 The module SHALL have port out_valid, output, 1, head entry is valid toward decode.
REQ-010 The module SHALL have port out_ready, input, 1, decode consumes the head entry this cycle.
REQ-011 The module SHALL have port out_pc_plus_1, output, 32, head entry PC+1.
REQ-012 The module SHALL have port out_insn, output, 32, head entry instruction.
REQ-013 The module SHALL have port count, output, 3, number of valid entries, 0..DEPTH.

Function
REQ-014 Push SHALL occur when in_valid && in_ready && !flush; pop SHALL occur when out_valid && out_ready && !flush.
REQ-015 in_ready SHALL equal (count != DEPTH), combinational from state only; no dependency on out_ready.
REQ-016 out_valid SHALL equal (count != 0); out_pc_plus_1/out_insn SHALL be driven from the head storage entry with zero added latency.
REQ-017 Entry written on a push SHALL be visible at the head no earlier than the cycle after the push edge (minimum latency 1 cycle, no bypass).
REQ-018 Write and read pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; push writes at write pointer then increments it; pop increments read pointer.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when count == DEPTH is impossible for push (in_ready low) and when count == 0 is impossible for pop (out_valid low).
REQ-020 When full, in_valid SHALL be ignored and storage SHALL not change; when empty, out_ready SHALL be ignored.
REQ-021 flush SHALL, on the next edge, set count, write pointer, read pointer to 0; any coincident push and pop SHALL be discarded; storage contents need not be cleared.
REQ-022 When out_valid is 0, out_pc_plus_1 and out_insn SHALL be 32'd0 (masked), so decode sees a nop.
REQ-023 count SHALL never exceed DEPTH nor underflow below 0 under any input sequence.

Reset
REQ-024 reset SHALL have priority over flush, push and pop.
REQ-025 After reset: count=0, pointers=0, storage=0, out_valid=0, in_ready=1, out_pc_plus_1=0, out_insn=0.
REQ-026 reset asserted mid-operation SHALL drop all buffered entries on that edge; the first push is accepted on the first edge with reset low.

Structure
REQ-027 DEPTH legal values and the nop encoding (32'd0) SHALL live in the shared processor constants include file used by the pipeline stages.
REQ-028 Each storage entry SHALL be one instance of a 64-bit write-enabled register sub-module named register64 (clock, synchronous reset, enable, d, q).
REQ-029 Pointer/count logic SHALL be in fetch_queue itself; no other sub-modules.

Verification
REQ-030 Reset then idle: reset high 2 cycles -> count=0, out_valid=0, in_ready=1, out_insn=0.
REQ-031 Fill: push insn 32'hA1, 32'hA2 with out_ready=0 (DEPTH=2) -> count=2, in_ready=0, out_insn=32'hA1; third push 32'hA3 ignored.
REQ-032 Ordering/wrap: continuous push 32'h10..32'h17 with out_ready=1 -> outputs 32'h10..32'h17 in order, no loss or duplication, count stays 1 in steady state.
REQ-033 Simultaneous push/pop at count=1 (head 32'hB0, push 32'hB1) -> count stays 1, next head 32'hB1.
REQ-034 Flush with count=2 and coincident push 32'hC0 -> next cycle count=0, out_valid=0; 32'hC0 never appears.
REQ-035 Reset mid-stream at count=1 with coincident flush and push -> count=0; next push 32'hD0 appears as head one cycle later.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Processor-wide constants shared by the pipeline stages: fetch queue depth
// limits, the nop encoding and the buffered fetch entry layout.
package fetch_queue_pkg;

    localparam int unsigned FQ_DEPTH_SMALL = 2;
    localparam int unsigned FQ_DEPTH_LARGE = 4;

    localparam logic [31:0] NOP_INSN = 32'd0;

    typedef struct packed {
        logic [31:0] pc_plus_1;
        logic [31:0] insn;
    } fq_entry_t;

    function automatic bit fq_depth_legal(input int unsigned depth);
        return (depth == FQ_DEPTH_SMALL) || (depth == FQ_DEPTH_LARGE);
    endfunction

endpackage

// File: rtl/fetch_queue_register64.sv
// 64-bit write-enabled storage register holding one fetch queue entry.
module register64 (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [63:0] d,
    output logic [63:0] q
);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode skid queue: DEPTH-entry FIFO with flush, no bypass, and a
// nop-masked head so decode sees 32'd0 whenever the queue is empty.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc_plus_1,
    input  logic [31:0] in_insn,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc_plus_1,
    output logic [31:0] out_insn,
    output logic [2:0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    if (!fq_depth_legal(DEPTH)) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be 2 or 4");
    end

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;
    logic             push, pop;
    fq_entry_t        wr_entry;
    fq_entry_t        head;
    fq_entry_t        entry_q [DEPTH];

    assign in_ready  = (count_q != 3'(DEPTH));
    assign out_valid = (count_q != 3'd0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !flush;
    assign pop  = out_valid && out_ready && !flush;

    assign wr_entry = '{pc_plus_1: in_pc_plus_1, insn: in_insn};

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        register64 u_entry (
            .clock (clock),
            .reset (reset),
            .en    (push && (wr_ptr_q == PTR_W'(i))),
            .d     (wr_entry),
            .q     (entry_q[i])
        );
    end

    // Head is read straight from storage; an empty queue presents a nop.
    assign head          = entry_q[rd_ptr_q];
    assign out_pc_plus_1 = out_valid ? head.pc_plus_1 : NOP_INSN;
    assign out_insn      = out_valid ? head.insn      : NOP_INSN;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = 3'd0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
